// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and EX operand forward selects.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// EX-stage operand forward select for one source register; MEM wins over WB, r0 never forwarded.
module fwd_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] src_addr_i,
    input  logic       mem_we_i,
    input  logic [4:0] mem_dst_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_dst_i,
    output logic [1:0] sel_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_we_i && (mem_dst_i != 5'd0) && (mem_dst_i == src_addr_i);
    assign wb_hit  = wb_we_i  && (wb_dst_i  != 5'd0) && (wb_dst_i  == src_addr_i);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, branch flush, halt drain, forwarding.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [4:0]       ID_RSAddr,
    input  logic [4:0]       ID_RTAddr,
    input  logic             ID_UsesRT,
    input  logic             ID_Halt,
    input  logic [4:0]       EX_RSAddr,
    input  logic [4:0]       EX_RTAddr,
    input  logic             EX_RegWriteEN,
    input  logic             EX_Mem2RegSEL,
    input  logic [4:0]       EX_DstAddr,
    input  logic             EX_BranchTaken,
    input  logic             MEM_RegWriteEN,
    input  logic [4:0]       MEM_DstAddr,
    input  logic             WB_RegWriteEN,
    input  logic [4:0]       WB_DstAddr,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

    state_e            state_q, state_d;
    logic [DCNT_W-1:0] cnt_q, cnt_d;
    logic              loaduse;
    logic              pc_en, ifid_en, ifid_fl, idex_fl, halted;
    logic              take_stall, take_flush;
    logic [1:0]        fwd_a, fwd_b;

    assign loaduse = EX_RegWriteEN && EX_Mem2RegSEL && (EX_DstAddr != 5'd0) &&
                     ((EX_DstAddr == ID_RSAddr) || (ID_UsesRT && (EX_DstAddr == ID_RTAddr)));

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and pipeline controls; a branch outranks halt and load-use since ID is on the wrong path.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_fl    = 1'b0;
        idex_fl    = 1'b1;
        halted     = 1'b0;
        take_stall = 1'b0;
        take_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (EX_BranchTaken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_fl    = 1'b1;
                    take_flush = 1'b1;
                end else if (ID_Halt) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DCNT_W'(DRAIN_CYCLES - 1);
                end else if (loaduse) begin
                    take_stall = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    idex_fl = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - DCNT_W'(1);
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    fwd_sel u_fwd_a (
        .src_addr_i (EX_RSAddr),
        .mem_we_i   (MEM_RegWriteEN),
        .mem_dst_i  (MEM_DstAddr),
        .wb_we_i    (WB_RegWriteEN),
        .wb_dst_i   (WB_DstAddr),
        .sel_o      (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src_addr_i (EX_RTAddr),
        .mem_we_i   (MEM_RegWriteEN),
        .mem_dst_i  (MEM_DstAddr),
        .wb_we_i    (WB_RegWriteEN),
        .wb_dst_i   (WB_DstAddr),
        .sel_o      (fwd_b)
    );

    // Reset overrides every control so the pipeline loads bubbles while held.
    assign PC_EN      = !RESET && pc_en;
    assign IFID_EN    = !RESET && ifid_en;
    assign IFID_Flush = RESET || ifid_fl;
    assign IDEX_Flush = RESET || idex_fl;
    assign Halted     = !RESET && halted;
    assign ForwardA   = RESET ? FWD_RF : fwd_a;
    assign ForwardB   = RESET ? FWD_RF : fwd_b;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (take_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (take_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = take_stall ^ take_flush;
    assign StallCnt    = '0;
    assign FlushCnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle-count model.
module tb_hazard_ctrl;

    localparam int DC = 4;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_RSAddr, ID_RTAddr, EX_RSAddr, EX_RTAddr, EX_DstAddr, MEM_DstAddr, WB_DstAddr;
    logic        ID_UsesRT, ID_Halt, EX_RegWriteEN, EX_Mem2RegSEL, EX_BranchTaken;
    logic        MEM_RegWriteEN, WB_RegWriteEN;
    logic        PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] StallCnt, FlushCnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: halt time and cycle count define RUN/DRAIN/HALTED; counters are plain event tallies.
    int     cyc = 0;
    int     halt_t = -1;
    longint stall_n = 0;
    longint flush_n = 0;
    logic   e_pc, e_ifen, e_iff, e_idf, e_h;
    logic [1:0] e_fa, e_fb;

    hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ID_RSAddr(ID_RSAddr), .ID_RTAddr(ID_RTAddr), .ID_UsesRT(ID_UsesRT), .ID_Halt(ID_Halt),
        .EX_RSAddr(EX_RSAddr), .EX_RTAddr(EX_RTAddr), .EX_RegWriteEN(EX_RegWriteEN),
        .EX_Mem2RegSEL(EX_Mem2RegSEL), .EX_DstAddr(EX_DstAddr), .EX_BranchTaken(EX_BranchTaken),
        .MEM_RegWriteEN(MEM_RegWriteEN), .MEM_DstAddr(MEM_DstAddr),
        .WB_RegWriteEN(WB_RegWriteEN), .WB_DstAddr(WB_DstAddr),
        .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .Halted(Halted),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    // 0 = RUN, 1 = DRAIN, 2 = HALTED
    function automatic int mode();
        if (halt_t < 0) return 0;
        if (cyc - halt_t <= DC) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] perf_exp(longint n);
`ifdef HAZARD_PERF_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic logic [1:0] fwd_exp(logic [4:0] src);
        if (MEM_RegWriteEN && MEM_DstAddr != 0 && MEM_DstAddr == src) return 2'b01;
        if (WB_RegWriteEN && WB_DstAddr != 0 && WB_DstAddr == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_comb();
        logic lu;
        lu = EX_RegWriteEN && EX_Mem2RegSEL && EX_DstAddr != 0 &&
             (EX_DstAddr == ID_RSAddr || (ID_UsesRT && EX_DstAddr == ID_RTAddr));
        if (RESET) begin
            {e_pc, e_ifen, e_iff, e_idf, e_h} = 5'b00110;
            e_fa = 2'b00;
            e_fb = 2'b00;
        end else begin
            e_fa = fwd_exp(EX_RSAddr);
            e_fb = fwd_exp(EX_RTAddr);
            e_h  = (mode() == 2);
            if (mode() != 0)        {e_pc, e_ifen, e_iff, e_idf} = 4'b0001;
            else if (EX_BranchTaken) {e_pc, e_ifen, e_iff, e_idf} = 4'b1111;
            else if (ID_Halt)        {e_pc, e_ifen, e_iff, e_idf} = 4'b0001;
            else if (lu)             {e_pc, e_ifen, e_iff, e_idf} = 4'b0001;
            else                     {e_pc, e_ifen, e_iff, e_idf} = 4'b1100;
        end
    endtask

    task automatic model_clock();
        logic lu;
        lu = EX_RegWriteEN && EX_Mem2RegSEL && EX_DstAddr != 0 &&
             (EX_DstAddr == ID_RSAddr || (ID_UsesRT && EX_DstAddr == ID_RTAddr));
        if (RESET) begin
            cyc = 0; halt_t = -1; stall_n = 0; flush_n = 0;
        end else begin
            if (mode() == 0) begin
                if (EX_BranchTaken) flush_n++;
                else if (ID_Halt)   halt_t = cyc;
                else if (lu)        stall_n++;
            end
            cyc++;
        end
    endtask

    task automatic idle_inputs();
        ID_RSAddr = 0; ID_RTAddr = 0; ID_UsesRT = 0; ID_Halt = 0;
        EX_RSAddr = 0; EX_RTAddr = 0; EX_RegWriteEN = 0; EX_Mem2RegSEL = 0;
        EX_DstAddr = 0; EX_BranchTaken = 0;
        MEM_RegWriteEN = 0; MEM_DstAddr = 0; WB_RegWriteEN = 0; WB_DstAddr = 0;
    endtask

    // Advance one clock, updating the model at the edge; returns at the following falling edge.
    task automatic tick();
        @(posedge CLOCK);
        model_clock();
        @(negedge CLOCK);
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        idle_inputs();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle_inputs();
        MEM_RegWriteEN = 1; MEM_DstAddr = 5'd5; EX_RSAddr = 5'd5; EX_RTAddr = 5'd5;
        #1;
        n_tests++;
        if ({PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted} !== 5'b00110) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=00110", {PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted});
        end
        n_tests++;
        if ({ForwardA, ForwardB} !== 4'b0000 || StallCnt !== 0 || FlushCnt !== 0) begin
            n_fail++;
            $display("FAIL reset_fwd_cnt got fa=%b fb=%b sc=%0d fc=%0d exp 0", ForwardA, ForwardB, StallCnt, FlushCnt);
        end
        tick();
        RESET = 1'b0;
        idle_inputs();
        #1;
        n_tests++;
        if (PC_EN !== 1'b1 || IDEX_Flush !== 1'b0 || Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got pc=%b idf=%b h=%b exp 1/0/0", PC_EN, IDEX_Flush, Halted);
        end
    endtask

    task automatic test_loaduse();
        do_reset();
        EX_RegWriteEN = 1; EX_Mem2RegSEL = 1; EX_DstAddr = 5'd2; ID_RSAddr = 5'd2;
        #1;
        n_tests++;
        if ({PC_EN, IFID_EN, IDEX_Flush} !== 3'b001) begin
            n_fail++;
            $display("FAIL loaduse_stall got=%b exp=001", {PC_EN, IFID_EN, IDEX_Flush});
        end
        tick();
        idle_inputs();
        ID_RSAddr = 5'd2;
        #1;
        n_tests++;
        if ({PC_EN, IFID_EN, IDEX_Flush} !== 3'b110) begin
            n_fail++;
            $display("FAIL loaduse_one_cycle got=%b exp=110", {PC_EN, IFID_EN, IDEX_Flush});
        end
        n_tests++;
        if (StallCnt !== perf_exp(1) || FlushCnt !== perf_exp(0)) begin
            n_fail++;
            $display("FAIL loaduse_cnt got sc=%0d fc=%0d exp sc=%0d fc=%0d", StallCnt, FlushCnt, perf_exp(1), perf_exp(0));
        end
        // rt match only counts when the instruction actually reads rt
        EX_RegWriteEN = 1; EX_Mem2RegSEL = 1; EX_DstAddr = 5'd7; ID_RSAddr = 5'd1; ID_RTAddr = 5'd7; ID_UsesRT = 0;
        #1;
        n_tests++;
        if (PC_EN !== 1'b1) begin
            n_fail++;
            $display("FAIL loaduse_rt_unused got pc=%b exp=1", PC_EN);
        end
        ID_UsesRT = 1;
        #1;
        n_tests++;
        if (PC_EN !== 1'b0 || IDEX_Flush !== 1'b1) begin
            n_fail++;
            $display("FAIL loaduse_rt got pc=%b idf=%b exp 0/1", PC_EN, IDEX_Flush);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        do_reset();
        EX_RegWriteEN = 1; EX_Mem2RegSEL = 1; EX_DstAddr = 5'd3; ID_RSAddr = 5'd3;
        ID_Halt = 1; EX_BranchTaken = 1;
        #1;
        n_tests++;
        if ({PC_EN, IFID_EN, IFID_Flush, IDEX_Flush} !== 4'b1111) begin
            n_fail++;
            $display("FAIL branch_prio got=%b exp=1111", {PC_EN, IFID_EN, IFID_Flush, IDEX_Flush});
        end
        tick();
        idle_inputs();
        for (int i = 0; i < DC + 2; i++) begin
            #1;
            n_tests++;
            if (Halted !== 1'b0 || PC_EN !== 1'b1) begin
                n_fail++;
                $display("FAIL branch_stay_run i=%0d got h=%b pc=%b exp 0/1", i, Halted, PC_EN);
            end
            tick();
        end
        n_tests++;
        if (FlushCnt !== perf_exp(1) || StallCnt !== perf_exp(0)) begin
            n_fail++;
            $display("FAIL branch_cnt got fc=%0d sc=%0d exp fc=%0d sc=%0d", FlushCnt, StallCnt, perf_exp(1), perf_exp(0));
        end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        MEM_RegWriteEN = 1; WB_RegWriteEN = 1; MEM_DstAddr = 5'd5; WB_DstAddr = 5'd5; EX_RSAddr = 5'd5;
        #1;
        n_tests++;
        if (ForwardA !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_mem_prio got=%b exp=01", ForwardA);
        end
        MEM_DstAddr = 5'd0; WB_DstAddr = 5'd0; EX_RSAddr = 5'd0;
        #1;
        n_tests++;
        if (ForwardA !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_r0 got=%b exp=00", ForwardA);
        end
        MEM_DstAddr = 5'd9; WB_DstAddr = 5'd12; EX_RTAddr = 5'd12; EX_RSAddr = 5'd4;
        #1;
        n_tests++;
        if (ForwardB !== 2'b10 || ForwardA !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_wb_b got fb=%b fa=%b exp 10/00", ForwardB, ForwardA);
        end
        idle_inputs();
    endtask

    task automatic test_drain_halt();
        do_reset();
        ID_Halt = 1;
        #1;
        n_tests++;
        if ({PC_EN, IFID_EN, IDEX_Flush, Halted} !== 4'b0010) begin
            n_fail++;
            $display("FAIL halt_T got=%b exp=0010", {PC_EN, IFID_EN, IDEX_Flush, Halted});
        end
        tick();
        ID_Halt = 0;
        for (int k = 1; k <= DC; k++) begin
            EX_BranchTaken = (k == 2);
            #1;
            n_tests++;
            if ({PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted} !== 5'b00010) begin
                n_fail++;
                $display("FAIL drain k=%0d got=%b exp=00010", k, {PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted});
            end
            tick();
        end
        EX_BranchTaken = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if ({PC_EN, IFID_EN, IDEX_Flush, Halted} !== 4'b0011) begin
                n_fail++;
                $display("FAIL halted k=%0d got=%b exp=0011", k, {PC_EN, IFID_EN, IDEX_Flush, Halted});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        ID_Halt = 1;
        tick();
        ID_Halt = 0;
        tick();
        RESET = 1'b1;
        MEM_RegWriteEN = 1; MEM_DstAddr = 5'd6; EX_RSAddr = 5'd6;
        #1;
        n_tests++;
        if ({PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted, ForwardA} !== 7'b0011000) begin
            n_fail++;
            $display("FAIL reset_mid_drain got=%b exp=0011000", {PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted, ForwardA});
        end
        tick();
        RESET = 1'b0;
        idle_inputs();
        #1;
        n_tests++;
        if (PC_EN !== 1'b1 || Halted !== 1'b0 || IDEX_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drain_release got pc=%b h=%b idf=%b exp 1/0/0", PC_EN, Halted, IDEX_Flush);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        EX_RegWriteEN = 1; EX_Mem2RegSEL = 1; EX_DstAddr = 5'd0; ID_RSAddr = 5'd0; ID_UsesRT = 1;
        #1;
        n_tests++;
        if (PC_EN !== 1'b1 || IDEX_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_load got pc=%b idf=%b exp 1/0", PC_EN, IDEX_Flush);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 600; it++) begin
            if (mode() == 2 && cyc - halt_t > DC + 3) do_reset();
            ID_RSAddr      = 5'($urandom_range(0, 3));
            ID_RTAddr      = 5'($urandom_range(0, 3));
            ID_UsesRT      = 1'($urandom_range(0, 1));
            ID_Halt        = ($urandom_range(0, 29) == 0);
            EX_RSAddr      = 5'($urandom_range(0, 3));
            EX_RTAddr      = 5'($urandom_range(0, 3));
            EX_RegWriteEN  = 1'($urandom_range(0, 1));
            EX_Mem2RegSEL  = 1'($urandom_range(0, 1));
            EX_DstAddr     = 5'($urandom_range(0, 3));
            EX_BranchTaken = ($urandom_range(0, 4) == 0);
            MEM_RegWriteEN = 1'($urandom_range(0, 1));
            MEM_DstAddr    = 5'($urandom_range(0, 3));
            WB_RegWriteEN  = 1'($urandom_range(0, 1));
            WB_DstAddr     = 5'($urandom_range(0, 3));
            #1;
            model_comb();
            n_tests++;
            if ({PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted} !== {e_pc, e_ifen, e_iff, e_idf, e_h}) begin
                n_fail++;
                $display("FAIL rnd_ctrl it=%0d got=%b exp=%b", it,
                         {PC_EN, IFID_EN, IFID_Flush, IDEX_Flush, Halted}, {e_pc, e_ifen, e_iff, e_idf, e_h});
            end
            n_tests++;
            if ({ForwardA, ForwardB} !== {e_fa, e_fb}) begin
                n_fail++;
                $display("FAIL rnd_fwd it=%0d got=%b/%b exp=%b/%b", it, ForwardA, ForwardB, e_fa, e_fb);
            end
            n_tests++;
            if (StallCnt !== perf_exp(stall_n) || FlushCnt !== perf_exp(flush_n)) begin
                n_fail++;
                $display("FAIL rnd_cnt it=%0d got sc=%0d fc=%0d exp sc=%0d fc=%0d", it,
                         StallCnt, FlushCnt, perf_exp(stall_n), perf_exp(flush_n));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_loaduse();
        test_branch_priority();
        test_forwarding();
        test_drain_halt();
        test_reset_mid_drain();
        test_zero_reg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
